// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART TX FIFO write port
// and start_transmit strobe between two byte-stream requesters.
module uart_tx_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [DATA_WIDTH-1:0] req0_data,
   input  logic                  req0_last,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [DATA_WIDTH-1:0] req1_data,
   input  logic                  req1_last,
   output logic                  req1_ready,
   input  logic                  tx_almost_full,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  start_transmit,
   output logic [1:0]            grant,
   output logic                  busy
);

   // Handshake: a byte moves when reqN_valid && reqN_ready on a rising edge.
   // ready depends only on state, tx_almost_full and reset, never on valid.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GNT0 = 2'd1;
   localparam logic [1:0] ST_GNT1 = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST - 1);

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [7:0]            burst_cnt;
   logic [7:0]            burst_cnt_nxt;
   logic                  last_served;
   logic                  last_served_nxt;
   logic                  hs0;
   logic                  hs1;
   logic                  hs;
   logic                  hs_last;
   logic                  grant_end;
   logic [DATA_WIDTH-1:0] hs_data;

   // Gating with reset keeps a byte presented in the reset cycle from being consumed.
   assign req0_ready = (state == ST_GNT0) && !tx_almost_full && !reset;
   assign req1_ready = (state == ST_GNT1) && !tx_almost_full && !reset;

   assign hs0       = req0_valid && req0_ready;
   assign hs1       = req1_valid && req1_ready;
   assign hs        = hs0 || hs1;
   assign hs_data   = hs1 ? req1_data : req0_data;
   assign hs_last   = hs1 ? req1_last : req0_last;
   assign grant_end = hs && (hs_last || (burst_cnt == BURST_LIMIT));

   always_comb begin
      state_nxt       = state;
      burst_cnt_nxt   = burst_cnt;
      last_served_nxt = last_served;
      case (state)
         ST_IDLE: begin
            if (req0_valid && (!req1_valid || last_served)) begin
               state_nxt = ST_GNT0;
            end else if (req1_valid) begin
               state_nxt = ST_GNT1;
            end
         end
         ST_GNT0, ST_GNT1: begin
            if (grant_end) begin
               state_nxt       = ST_DONE;
               burst_cnt_nxt   = 8'd0;
               last_served_nxt = (state == ST_GNT1);
            end else if (hs) begin
               burst_cnt_nxt = burst_cnt + 8'd1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // grant/busy are derived from the next state so they track the registered state exactly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         burst_cnt      <= 8'd0;
         last_served    <= 1'b1;
         wr_en          <= 1'b0;
         data_in        <= '0;
         start_transmit <= 1'b0;
         grant          <= 2'b00;
         busy           <= 1'b0;
      end else begin
         state          <= state_nxt;
         burst_cnt      <= burst_cnt_nxt;
         last_served    <= last_served_nxt;
         wr_en          <= hs;
         if (hs) begin
            data_in <= hs_data;
         end
         // Fires the cycle after DONE, once the FIFO holds the grant's final byte.
         start_transmit <= (state == ST_DONE);
         grant          <= {state_nxt == ST_GNT1, state_nxt == ST_GNT0};
         busy           <= (state_nxt != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (MAX_BURST = 4): scripted requester streams,
// FIFO-order scoreboard, per-cycle latency and start_transmit timing checks.
module tb_uart_tx_arbiter;

   localparam int DW        = 8;
   localparam int MAX_BURST = 4;

   logic          clk;
   logic          reset;
   logic          req0_valid;
   logic [DW-1:0] req0_data;
   logic          req0_last;
   logic          req0_ready;
   logic          req1_valid;
   logic [DW-1:0] req1_data;
   logic          req1_last;
   logic          req1_ready;
   logic          tx_almost_full;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic          start_transmit;
   logic [1:0]    grant;
   logic          busy;

   logic [DW:0]   stim0_q[$];
   logic [DW:0]   stim1_q[$];
   logic [DW-1:0] exp_q[$];

   int vectors     = 0;
   int miscompares = 0;
   int st_count    = 0;

   uart_tx_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk            (clk),
      .reset          (reset),
      .req0_valid     (req0_valid),
      .req0_data      (req0_data),
      .req0_last      (req0_last),
      .req0_ready     (req0_ready),
      .req1_valid     (req1_valid),
      .req1_data      (req1_data),
      .req1_last      (req1_last),
      .req1_ready     (req1_ready),
      .tx_almost_full (tx_almost_full),
      .wr_en          (wr_en),
      .data_in        (data_in),
      .start_transmit (start_transmit),
      .grant          (grant),
      .busy           (busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // driver: inputs change 1 time unit after the rising edge
   initial begin
      logic take0;
      logic take1;
      req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
      req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
      forever begin
         @(negedge clk);
         take0 = req0_valid && req0_ready;
         take1 = req1_valid && req1_ready;
         @(posedge clk);
         #1;
         if (take0 && stim0_q.size() > 0) void'(stim0_q.pop_front());
         if (take1 && stim1_q.size() > 0) void'(stim1_q.pop_front());
         if (stim0_q.size() > 0) begin
            req0_valid = 1'b1;
            {req0_last, req0_data} = stim0_q[0];
         end else begin
            req0_valid = 1'b0;
            req0_last  = 1'b0;
         end
         if (stim1_q.size() > 0) begin
            req1_valid = 1'b1;
            {req1_last, req1_data} = stim1_q[0];
         end else begin
            req1_valid = 1'b0;
            req1_last  = 1'b0;
         end
      end
   end

   task automatic add_stim(input int req, input logic [DW-1:0] d, input logic last);
      if (req == 0) stim0_q.push_back({last, d});
      else          stim1_q.push_back({last, d});
   endtask

   // scoreboard / monitor, sampled on the falling edge
   logic hs_prev = 1'b0;
   logic fin_d1  = 1'b0;
   logic fin_d2  = 1'b0;
   logic rst_d1  = 1'b1;
   int   burst_model = 0;

   always @(negedge clk) begin : monitor
      logic          hs0;
      logic          hs1;
      logic          lst;
      logic          fin;
      logic [DW-1:0] exp;
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      check_vec("wr_en_latency", 32'(wr_en), 32'(hs_prev));
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            check_vec("unexpected_write", 32'(data_in), 32'hffff_ffff);
         end else begin
            exp = exp_q.pop_front();
            check_vec("fifo_data", 32'(data_in), 32'(exp));
         end
      end
      check_vec("start_timing", 32'(start_transmit), 32'(fin_d2 && !rst_d1));
      if (start_transmit) st_count++;
      check_vec("ready_exclusive", 32'(req0_ready && req1_ready), 32'd0);
      if (tx_almost_full) check_vec("ready_afull", 32'(req0_ready || req1_ready), 32'd0);
      if (reset)          check_vec("ready_reset", 32'(req0_ready || req1_ready), 32'd0);
      fin = 1'b0;
      if (reset) begin
         burst_model = 0;
      end else if (hs0 || hs1) begin
         lst = hs0 ? req0_last : req1_last;
         burst_model++;
         if (lst || burst_model == MAX_BURST) begin
            fin = 1'b1;
            burst_model = 0;
         end
      end
      hs_prev = hs0 || hs1;
      fin_d2  = fin_d1;
      fin_d1  = fin;
      rst_d1  = reset;
   end

   task automatic do_reset(input int cycles);
      @(posedge clk); #2;
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   task automatic wait_hs0();
      int n = 0;
      @(negedge clk);
      while (!(req0_valid && req0_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_vec("hs0_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (!(stim0_q.size() == 0 && stim1_q.size() == 0 && exp_q.size() == 0 && !busy)
             && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check_vec({tag, "_drain_timeout"}, 32'd0, 32'd1);
      repeat (4) @(negedge clk);
      check_vec({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int st0;
      int n;
      logic [DW-1:0] rb [4];
      reset          = 1'b1;
      tx_almost_full = 1'b0;

      // reset with both requesters valid; requester 0 must win first
      add_stim(0, 8'hA5, 1'b1);
      add_stim(1, 8'hB6, 1'b1);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'hB6);
      st0 = st_count;
      repeat (2) begin
         @(negedge clk);
         check_vec("rst_wr_en", 32'(wr_en), 32'd0);
         check_vec("rst_data_in", 32'(data_in), 32'd0);
         check_vec("rst_start", 32'(start_transmit), 32'd0);
         check_vec("rst_grant", 32'(grant), 32'd0);
         check_vec("rst_busy", 32'(busy), 32'd0);
         check_vec("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
      end
      @(posedge clk); #2;
      reset = 1'b0;
      n = 0;
      @(negedge clk);
      while (grant == 2'b00 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_vec("first_grant", 32'(grant), 32'b01);
      drain("reset");
      check_vec("reset_st_count", 32'(st_count - st0), 32'd2);

      // single packet from requester 0
      st0 = st_count;
      @(posedge clk); #2;
      add_stim(0, 8'd20, 1'b0); add_stim(0, 8'd40, 1'b0); add_stim(0, 8'd60, 1'b1);
      exp_q.push_back(8'd20); exp_q.push_back(8'd40); exp_q.push_back(8'd60);
      drain("single");
      check_vec("single_st_count", 32'(st_count - st0), 32'd1);

      // contention from reset, two packets each: strict alternation
      do_reset(2);
      st0 = st_count;
      add_stim(0, 8'd20, 1'b0); add_stim(0, 8'd40, 1'b0); add_stim(0, 8'd60, 1'b1);
      add_stim(0, 8'd21, 1'b0); add_stim(0, 8'd41, 1'b0); add_stim(0, 8'd61, 1'b1);
      add_stim(1, 8'd10, 1'b0); add_stim(1, 8'd30, 1'b0); add_stim(1, 8'd50, 1'b1);
      add_stim(1, 8'd11, 1'b0); add_stim(1, 8'd31, 1'b0); add_stim(1, 8'd51, 1'b1);
      exp_q.push_back(8'd20); exp_q.push_back(8'd40); exp_q.push_back(8'd60);
      exp_q.push_back(8'd10); exp_q.push_back(8'd30); exp_q.push_back(8'd50);
      exp_q.push_back(8'd21); exp_q.push_back(8'd41); exp_q.push_back(8'd61);
      exp_q.push_back(8'd11); exp_q.push_back(8'd31); exp_q.push_back(8'd51);
      drain("contention");
      check_vec("contention_st_count", 32'(st_count - st0), 32'd4);

      // burst cap: requester 1 was served last, so requester 0 goes first
      st0 = st_count;
      @(posedge clk); #2;
      for (int i = 1; i <= 10; i++) add_stim(0, 8'(i), i == 10);
      add_stim(1, 8'd99, 1'b1);
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'd99);
      for (int i = 5; i <= 10; i++) exp_q.push_back(8'(i));
      drain("burst");
      check_vec("burst_st_count", 32'(st_count - st0), 32'd4);

      // backpressure mid-packet, random payload
      st0 = st_count;
      @(posedge clk); #2;
      for (int i = 0; i < 4; i++) begin
         rb[i] = 8'($urandom_range(0, 255));
         add_stim(0, rb[i], i == 3);
         exp_q.push_back(rb[i]);
      end
      wait_hs0();
      @(posedge clk); #2;
      tx_almost_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_vec("bp_ready", 32'(req0_ready), 32'd0);
         check_vec("bp_grant", 32'(grant), 32'b01);
         check_vec("bp_busy", 32'(busy), 32'd1);
         if (i > 0) check_vec("bp_wr_en", 32'(wr_en), 32'd0);
      end
      @(posedge clk); #2;
      tx_almost_full = 1'b0;
      drain("backpressure");
      check_vec("bp_st_count", 32'(st_count - st0), 32'd1);

      // reset during byte 2 of 4: only byte 1 reaches the FIFO
      st0 = st_count;
      @(posedge clk); #2;
      add_stim(0, 8'hC1, 1'b0); add_stim(0, 8'hC2, 1'b0);
      add_stim(0, 8'hC3, 1'b0); add_stim(0, 8'hC4, 1'b1);
      exp_q.push_back(8'hC1);
      wait_hs0();
      @(posedge clk); #2;
      reset = 1'b1;
      stim0_q.delete();
      @(posedge clk); #2;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_vec("mid_rst_wr_en", 32'(wr_en), 32'd0);
         check_vec("mid_rst_start", 32'(start_transmit), 32'd0);
         check_vec("mid_rst_grant", 32'(grant), 32'd0);
         check_vec("mid_rst_busy", 32'(busy), 32'd0);
      end
      drain("mid_reset");
      check_vec("mid_rst_st_count", 32'(st_count - st0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
